// File: rtl/result_writer.sv
// result_writer: writes systolic-array result columns into slice-major result memory C.
// Optional build macro RESULT_WRITER_RELU_EN clamps negative elements to zero on load.
module result_writer #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8,
    parameter int DW = 16,
    localparam int AW = ((M * M / N1) > 1) ? $clog2(M * M / N1) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [N1*DW-1:0] i_in_data,
    output logic             o_wr_en,
    input  logic             i_wr_ready,
    output logic [AW-1:0]    o_wr_addr,
    output logic [N1*DW-1:0] o_wr_data,
    output logic             o_busy,
    output logic             o_done
);
    localparam int NCB = M / N2;
    localparam int NSL = M / N1;
    localparam int BW  = (N2 > 1) ? $clog2(N2) : 1;
    localparam int CW  = (NCB > 1) ? $clog2(NCB) : 1;
    localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;

    // state | meaning
    // IDLE  | waiting for start, no columns accepted
    // RUN   | accepting result columns into the output register
    // DRAIN | final column accepted, waiting for its write to C
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [BW-1:0]    r_beat;
    logic [CW-1:0]    r_cblk;
    logic [SW-1:0]    r_slice;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [N1*DW-1:0] r_wr_data;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_drain;
    logic             w_last;
    logic [AW-1:0]    w_addr;
    logic [N1*DW-1:0] w_load;

    assign o_in_ready = (r_state == RUN) && (!r_wr_en || i_wr_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_drain    = r_wr_en && i_wr_ready;
    assign w_last     = (r_beat == BW'(N2 - 1)) && (r_cblk == CW'(NCB - 1))
                        && (r_slice == SW'(NSL - 1));
    // Slice-major layout shared with operand memory A: column + slice*M.
    assign w_addr     = AW'(r_cblk) * AW'(N2) + AW'(r_beat) + AW'(r_slice) * AW'(M);

    always_comb begin
        w_load = i_in_data;
`ifdef RESULT_WRITER_RELU_EN
        for (int k = 0; k < N1; k++) begin
            if (i_in_data[k*DW + DW - 1]) begin
                w_load[k*DW +: DW] = '0;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_cblk    <= '0;
            r_slice   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_beat  <= '0;
                        r_cblk  <= '0;
                        r_slice <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr;
                        r_wr_data <= w_load;
                        if (r_beat == BW'(N2 - 1)) begin
                            r_beat <= '0;
                            if (r_cblk == CW'(NCB - 1)) begin
                                r_cblk  <= '0;
                                r_slice <= (r_slice == SW'(NSL - 1)) ? '0 : r_slice + 1'b1;
                            end else begin
                                r_cblk <= r_cblk + 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end else if (w_drain) begin
                        r_wr_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_drain) begin
                        r_wr_en <= 1'b0;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
endmodule
